// File: rtl/bpu_pkg.sv
// -----------------------------------------------------------------------------
// bpu_pkg
// Shared definitions for the hybrid branch predictor:
//   - predictor mode encodings (local / gshare / tournament)
//   - 2-bit saturating counter state encodings and table reset values
//   - satUpd(): one step of a 2-bit saturating counter toward taken/not-taken
// -----------------------------------------------------------------------------
package bpu_pkg;

    localparam int MODE_LOCAL  = 0;
    localparam int MODE_GSHARE = 1;
    localparam int MODE_TOURN  = 2;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } satState_t;

    // Direction tables start weakly not-taken; the chooser starts weakly global.
    localparam logic [1:0] PHT_RST  = CNT_WNT;
    localparam logic [1:0] CPHT_RST = CNT_WT;

    function automatic logic [1:0] satUpd(input logic [1:0] cnt, input logic up);
        logic [1:0] nxt;
        nxt = cnt;
        if (up) begin
            if (cnt != CNT_ST) nxt = cnt + 2'd1;
        end else begin
            if (cnt != CNT_SNT) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sat_cnt2.sv
// -----------------------------------------------------------------------------
// sat_cnt2
// One 2-bit saturating counter. inc/dec are mutually exclusive step enables.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset (loads RST_VAL)
//   inc  - step toward strongly taken
//   dec  - step toward strongly not-taken
//   cnt  - current counter state
// -----------------------------------------------------------------------------
module sat_cnt2
    import bpu_pkg::*;
#(
    parameter logic [1:0] RST_VAL = PHT_RST
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= RST_VAL;
        end else if (inc) begin
            cnt <= satUpd(cnt, 1'b1);
        end else if (dec) begin
            cnt <= satUpd(cnt, 1'b0);
        end
    end

endmodule

// File: rtl/bpu_hybrid.sv
// -----------------------------------------------------------------------------
// bpu_hybrid
// Local / gshare / tournament conditional branch predictor.
// Lookup is combinational from pcF and registered into the D stage; tables are
// trained non-speculatively when the branch resolves in M.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   pcF           - fetch PC used for the lookup
//   stallD/flushD - hold / clear the D-stage prediction register (flush wins)
//   branchD       - D-stage instruction is a conditional branch
//   pred_takeD    - predicted taken for the D-stage branch
//   pcM           - PC of the resolving branch
//   branchM       - M-stage instruction is a conditional branch
//   actual_takeM  - resolved direction
//   pred_takeM    - prediction that travelled with the branch
//   mispredM      - misprediction flag (combinational)
//   br_cnt        - resolved-branch count (saturating)
//   mis_cnt       - misprediction count (saturating)
// -----------------------------------------------------------------------------
module bpu_hybrid
    import bpu_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int IDX_W   = 6,
    parameter int LHIST_W = 4,
    parameter int GHR_W   = 8,
    parameter int MODE    = MODE_TOURN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pcF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            branchD,
    output logic            pred_takeD,
    input  logic [PC_W-1:0] pcM,
    input  logic            branchM,
    input  logic            actual_takeM,
    input  logic            pred_takeM,
    output logic            mispredM,
    output logic [31:0]     br_cnt,
    output logic [31:0]     mis_cnt
);

    localparam int N_BHT  = 1 << IDX_W;
    localparam int N_LPHT = 1 << LHIST_W;
    localparam int N_GPHT = 1 << GHR_W;
    localparam int HI_BIT = ((IDX_W > GHR_W) ? IDX_W : GHR_W) + 1;

    // Tables belonging to a component the mode does not use are never trained.
    localparam bit USE_LOCAL  = (MODE != MODE_GSHARE);
    localparam bit USE_GLOBAL = (MODE != MODE_LOCAL);
    localparam bit USE_CHOOSE = (MODE == MODE_TOURN);

    function automatic logic [31:0] satInc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    logic [LHIST_W-1:0] bht  [N_BHT];
    logic [GHR_W-1:0]   ghr;
    logic [1:0]         lpht [N_LPHT];
    logic [1:0]         gpht [N_GPHT];
    logic [1:0]         cpht [N_GPHT];

    logic [N_LPHT-1:0]  lphtInc, lphtDec;
    logic [N_GPHT-1:0]  gphtInc, gphtDec;
    logic [N_GPHT-1:0]  cphtInc, cphtDec;

    // ---- F stage: combinational lookup on current table contents ----
    logic [IDX_W-1:0]   lIdxF;
    logic [LHIST_W-1:0] lHistF;
    logic [GHR_W-1:0]   gIdxF;
    logic               localPredF, globalPredF, chooseGlobalF, predF;

    assign lIdxF         = pcF[IDX_W+1:2];
    assign lHistF        = bht[lIdxF];
    assign gIdxF         = pcF[GHR_W+1:2] ^ ghr;
    assign localPredF    = lpht[lHistF][1];
    assign globalPredF   = gpht[gIdxF][1];
    assign chooseGlobalF = cpht[gIdxF][1];

    always_comb begin
        predF = localPredF;
        if (MODE == MODE_GSHARE) begin
            predF = globalPredF;
        end else if (MODE == MODE_TOURN) begin
            predF = chooseGlobalF ? globalPredF : localPredF;
        end
    end

    // ---- F -> D boundary: prediction register ----
    logic predTake_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            predTake_p1 <= 1'b0;
        end else if (flushD) begin
            predTake_p1 <= 1'b0;
        end else if (!stallD) begin
            predTake_p1 <= predF;
        end
    end

    assign pred_takeD = branchD & predTake_p1;

    // ---- M stage: resolution and training from pre-update state ----
    logic [IDX_W-1:0]   lIdxM;
    logic [LHIST_W-1:0] lHistM;
    logic [GHR_W-1:0]   gIdxM;
    logic               localOkM, globalOkM;
    logic               updLocal, updGlobal, updChoose;

    assign lIdxM     = pcM[IDX_W+1:2];
    assign lHistM    = bht[lIdxM];
    assign gIdxM     = pcM[GHR_W+1:2] ^ ghr;
    assign localOkM  = (lpht[lHistM][1] == actual_takeM);
    assign globalOkM = (gpht[gIdxM][1] == actual_takeM);

    assign updLocal  = branchM & USE_LOCAL;
    assign updGlobal = branchM & USE_GLOBAL;
    // The chooser only learns when the components disagree in correctness.
    assign updChoose = branchM & USE_CHOOSE & (localOkM ^ globalOkM);

    assign mispredM  = branchM & (actual_takeM ^ pred_takeM);

    always_comb begin
        lphtInc = '0;
        lphtDec = '0;
        gphtInc = '0;
        gphtDec = '0;
        cphtInc = '0;
        cphtDec = '0;
        if (updLocal) begin
            lphtInc[lHistM] = actual_takeM;
            lphtDec[lHistM] = !actual_takeM;
        end
        if (updGlobal) begin
            gphtInc[gIdxM] = actual_takeM;
            gphtDec[gIdxM] = !actual_takeM;
        end
        if (updChoose) begin
            cphtInc[gIdxM] = globalOkM;
            cphtDec[gIdxM] = localOkM;
        end
    end

    for (genvar i = 0; i < N_LPHT; i++) begin : gLpht
        sat_cnt2 #(.RST_VAL(PHT_RST)) uCnt (
            .clk(clk), .rst(rst), .inc(lphtInc[i]), .dec(lphtDec[i]), .cnt(lpht[i])
        );
    end

    for (genvar i = 0; i < N_GPHT; i++) begin : gGpht
        sat_cnt2 #(.RST_VAL(PHT_RST)) uCnt (
            .clk(clk), .rst(rst), .inc(gphtInc[i]), .dec(gphtDec[i]), .cnt(gpht[i])
        );
        sat_cnt2 #(.RST_VAL(CPHT_RST)) uChoose (
            .clk(clk), .rst(rst), .inc(cphtInc[i]), .dec(cphtDec[i]), .cnt(cpht[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_BHT; i++) bht[i] <= '0;
        end else if (updLocal) begin
            bht[lIdxM] <= {lHistM[LHIST_W-2:0], actual_takeM};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr <= '0;
        end else if (updGlobal) begin
            ghr <= {ghr[GHR_W-2:0], actual_takeM};
        end
    end

    // ---- M -> W boundary: statistics ----
    logic [31:0] brCnt, misCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            brCnt  <= '0;
            misCnt <= '0;
        end else begin
            if (branchM)  brCnt  <= satInc32(brCnt);
            if (mispredM) misCnt <= satInc32(misCnt);
        end
    end

    assign br_cnt  = brCnt;
    assign mis_cnt = misCnt;

    // PC alignment bits and bits above the widest index never affect prediction.
    logic unusedPcBits;
    assign unusedPcBits = ^{pcF[PC_W-1:HI_BIT+1], pcF[1:0], pcM[PC_W-1:HI_BIT+1], pcM[1:0]};

endmodule

// File: tb/tb_bpu_hybrid.sv
// -----------------------------------------------------------------------------
// tb_bpu_hybrid
// Drives one stimulus stream into three predictors (local, gshare, tournament)
// and compares every output against an array-based model of the predictor rules.
// -----------------------------------------------------------------------------
module tb_bpu_hybrid;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pcF = '0, pcM = '0;
    logic        stallD = 1'b0, flushD = 1'b0, branchD = 1'b0;
    logic        branchM = 1'b0, actTake = 1'b0, predTakeM = 1'b0;
    logic [2:0]  predTakeD, mispredM;
    logic [31:0] brCnt [3];
    logic [31:0] misCnt [3];

    int nAssert = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    bpu_hybrid #(.MODE(0)) u0 (
        .clk(clk), .rst(rst), .pcF(pcF), .stallD(stallD), .flushD(flushD),
        .branchD(branchD), .pred_takeD(predTakeD[0]), .pcM(pcM), .branchM(branchM),
        .actual_takeM(actTake), .pred_takeM(predTakeM), .mispredM(mispredM[0]),
        .br_cnt(brCnt[0]), .mis_cnt(misCnt[0])
    );
    bpu_hybrid #(.MODE(1)) u1 (
        .clk(clk), .rst(rst), .pcF(pcF), .stallD(stallD), .flushD(flushD),
        .branchD(branchD), .pred_takeD(predTakeD[1]), .pcM(pcM), .branchM(branchM),
        .actual_takeM(actTake), .pred_takeM(predTakeM), .mispredM(mispredM[1]),
        .br_cnt(brCnt[1]), .mis_cnt(misCnt[1])
    );
    bpu_hybrid #(.MODE(2)) u2 (
        .clk(clk), .rst(rst), .pcF(pcF), .stallD(stallD), .flushD(flushD),
        .branchD(branchD), .pred_takeD(predTakeD[2]), .pcM(pcM), .branchM(branchM),
        .actual_takeM(actTake), .pred_takeM(predTakeM), .mispredM(mispredM[2]),
        .br_cnt(brCnt[2]), .mis_cnt(misCnt[2])
    );

    // Reference model: plain integer counters 0..3, histories as integers.
    int          mBht  [3][64];
    int          mLpht [3][16];
    int          mGpht [3][256];
    int          mCpht [3][256];
    int          mGhr  [3];
    bit          mD    [3];
    logic [31:0] mBr   [3];
    logic [31:0] mMis  [3];
    logic        lastMis1;

    task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nAssert++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < 64; i++)  mBht[m][i]  = 0;
            for (int i = 0; i < 16; i++)  mLpht[m][i] = 1;
            for (int i = 0; i < 256; i++) begin
                mGpht[m][i] = 1;
                mCpht[m][i] = 2;
            end
            mGhr[m] = 0;
            mD[m]   = 1'b0;
            mBr[m]  = '0;
            mMis[m] = '0;
        end
    endtask

    function automatic int lIdx(input logic [31:0] pc);
        return int'((pc >> 2) % 32'd64);
    endfunction

    function automatic int gIdx(input int m, input logic [31:0] pc);
        return int'((pc >> 2) % 32'd256) ^ mGhr[m];
    endfunction

    function automatic int step(input int c, input bit up);
        if (up) return (c == 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    function automatic bit modelPred(input int m, input logic [31:0] pc);
        bit lp, gp, ch;
        lp = mLpht[m][mBht[m][lIdx(pc)]] >= 2;
        gp = mGpht[m][gIdx(m, pc)] >= 2;
        ch = mCpht[m][gIdx(m, pc)] >= 2;
        if (m == 0) return lp;
        if (m == 1) return gp;
        return ch ? gp : lp;
    endfunction

    // Applies one rising edge to the model; all reads happen before any write.
    task automatic modelEdge();
        bit pf, lOk, gOk, mis;
        int l, h, g;
        mis = branchM & (actTake ^ predTakeM);
        for (int m = 0; m < 3; m++) begin
            pf = modelPred(m, pcF);
            if (branchM) begin
                l   = lIdx(pcM);
                h   = mBht[m][l];
                g   = gIdx(m, pcM);
                lOk = ((mLpht[m][h] >= 2) == actTake);
                gOk = ((mGpht[m][g] >= 2) == actTake);
                if (m != 1) begin
                    mLpht[m][h] = step(mLpht[m][h], actTake);
                    mBht[m][l]  = (h * 2 + int'(actTake)) % 16;
                end
                if (m != 0) begin
                    mGpht[m][g] = step(mGpht[m][g], actTake);
                    mGhr[m]     = (mGhr[m] * 2 + int'(actTake)) % 256;
                end
                if (m == 2 && lOk != gOk) mCpht[m][g] = step(mCpht[m][g], gOk);
                if (mBr[m] != 32'hFFFF_FFFF) mBr[m] = mBr[m] + 32'd1;
            end
            if (mis && mMis[m] != 32'hFFFF_FFFF) mMis[m] = mMis[m] + 32'd1;
            if (flushD)       mD[m] = 1'b0;
            else if (!stallD) mD[m] = pf;
        end
    endtask

    // Inputs are set by the caller just after an edge; one call = one clock.
    task automatic cycle();
        #1;
        for (int m = 0; m < 3; m++)
            expectEq($sformatf("mispredM_m%0d", m), 32'(mispredM[m]),
                     32'(branchM & (actTake ^ predTakeM)));
        lastMis1 = mispredM[1];
        @(posedge clk);
        modelEdge();
        #1;
        for (int m = 0; m < 3; m++) begin
            expectEq($sformatf("predD_m%0d", m), 32'(predTakeD[m]), 32'(branchD & mD[m]));
            expectEq($sformatf("brCnt_m%0d", m), brCnt[m], mBr[m]);
            expectEq($sformatf("misCnt_m%0d", m), misCnt[m], mMis[m]);
        end
    endtask

    task automatic doReset();
        {stallD, flushD, branchD, branchM, actTake, predTakeM} = '0;
        pcF = '0;
        pcM = '0;
        rst = 1'b0;
        modelReset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic randomCycles(input int n);
        logic [31:0] pcTab [8];
        pcTab = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104, 32'h200, 32'h3FC, 32'h0};
        for (int i = 0; i < n; i++) begin
            pcTab[7]  = $urandom & 32'hFFC;
            pcF       = pcTab[$urandom_range(0, 7)];
            pcM       = pcTab[$urandom_range(0, 7)];
            branchD   = 1'($urandom_range(0, 1));
            branchM   = 1'($urandom_range(0, 1));
            actTake   = 1'($urandom_range(0, 1));
            predTakeM = 1'($urandom_range(0, 1));
            stallD    = ($urandom_range(0, 4) == 0);
            flushD    = ($urandom_range(0, 9) == 0);
            cycle();
        end
        {stallD, flushD} = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lateMis;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b0;
        #1;
        modelReset();
        for (int m = 0; m < 3; m++) begin
            expectEq("rst_predD", 32'(predTakeD[m]), 32'd0);
            expectEq("rst_brCnt", brCnt[m], 32'd0);
            expectEq("rst_misCnt", misCnt[m], 32'd0);
        end
        expectEq("rst_cpht_init", 32'(u2.cpht[0]), 32'd2);
        expectEq("rst_gpht_init", 32'(u1.gpht[0]), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Local history saturates to all ones; the all-ones pattern then trains once.
        branchM = 1'b1; pcM = 32'h100; actTake = 1'b1; predTakeM = 1'b0;
        repeat (5) cycle();
        expectEq("bht0_ones", 32'(u0.bht[0]), 32'hF);
        branchM = 1'b0; branchD = 1'b1; pcF = 32'h100; flushD = 1'b1;
        cycle();
        expectEq("local_flushed", 32'(predTakeD[0]), 32'd0);
        flushD = 1'b0;
        cycle();
        expectEq("local_lat1", 32'(predTakeD[0]), 32'd1);

        // Alternating pattern: gshare learns it completely.
        doReset();
        pcF = 32'h200; branchD = 1'b1; branchM = 1'b1; pcM = 32'h200;
        lateMis = 0;
        for (int i = 0; i < 32; i++) begin
            actTake   = (i % 2 == 0);
            predTakeM = modelPred(1, 32'h200);
            cycle();
            if (i >= 16) lateMis += int'(lastMis1);
        end
        expectEq("gshare_late_mis", 32'(lateMis), 32'd0);

        // Chooser walks 10 -> 01 -> 00 when only the local component is right.
        doReset();
        branchM = 1'b1; predTakeM = 1'b0;
        pcM = 32'h4; actTake = 1'b1; cycle();
        expectEq("cpht_init", 32'(u2.cpht[2]), 32'd2);
        pcM = 32'hC; actTake = 1'b1; cycle();
        expectEq("cpht_step1", 32'(u2.cpht[2]), 32'd1);
        pcM = 32'h4; actTake = 1'b0; cycle();
        expectEq("cpht_step2", 32'(u2.cpht[2]), 32'd0);
        branchM = 1'b0; pcF = 32'h10; branchD = 1'b1;
        cycle();
        expectEq("tourn_follows_local", 32'(predTakeD[2]), 32'd1);
        expectEq("gshare_alone", 32'(predTakeD[1]), 32'd0);

        // Stall holds the registered prediction; flush beats stall.
        stallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pcF = 32'h40 + 32'(i * 4);
            cycle();
            expectEq("stall_hold", 32'(predTakeD[2]), 32'd1);
        end
        flushD = 1'b1;
        cycle();
        expectEq("flush_over_stall", 32'(predTakeD), 32'd0);
        stallD = 1'b0; flushD = 1'b0;

        // Branch counter saturation from a preloaded value.
        branchM = 1'b0;
        force u2.brCnt = 32'hFFFF_FFFE;
        mBr[2] = 32'hFFFF_FFFE;
        cycle();
        release u2.brCnt;
        branchM = 1'b1; actTake = 1'b0; predTakeM = 1'b0;
        repeat (3) cycle();
        expectEq("brcnt_sat", brCnt[2], 32'hFFFF_FFFF);
        branchM = 1'b0;

        randomCycles(400);

        // Asynchronous reset in the middle of an update cycle.
        branchM = 1'b1; actTake = 1'b1; predTakeM = 1'b0; pcM = 32'h100; branchD = 1'b1;
        #3 rst = 1'b0;
        #1;
        for (int m = 0; m < 3; m++) begin
            expectEq("arst_predD", 32'(predTakeD[m]), 32'd0);
            expectEq("arst_brCnt", brCnt[m], 32'd0);
            expectEq("arst_misCnt", misCnt[m], 32'd0);
            expectEq("arst_mispredM", 32'(mispredM[m]), 32'(branchM & (actTake ^ predTakeM)));
        end
        expectEq("arst_lpht", 32'(u0.lpht[0]), 32'd1);
        expectEq("arst_gpht", 32'(u1.gpht[8'h40]), 32'd1);
        expectEq("arst_cpht", 32'(u2.cpht[2]), 32'd2);
        expectEq("arst_bht", 32'(u0.bht[0]), 32'd0);
        expectEq("arst_ghr", 32'(u1.ghr), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        expectEq("arst_hold_br", brCnt[2], 32'd0);
        expectEq("arst_hold_ghr", 32'(u2.ghr), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        randomCycles(60);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/bpu_hybrid.md
BPU_HYBRID -- requirements
Module: bpu_hybrid

Interface
REQ-001 Parameters: PC_W=32 (PC width); IDX_W=6 (local BHT index bits, 2^IDX_W entries); LHIST_W=4 (local history bits); GHR_W=8 (global history bits; PHT/CPHT depth 2^GHR_W); MODE=2 (0 local, 1 gshare, 2 tournament).
REQ-002 Ports, one per line (clock and reset first):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- pcF  in  PC_W  fetch PC.
- stallD  in  1  hold D-stage prediction register.
- flushD  in  1  clear D-stage prediction register.
- branchD  in  1  D-stage instruction is a conditional branch.
- pred_takeD  out  1  predicted taken.
- pcM  in  PC_W  PC of resolving instruction.
- branchM  in  1  M-stage instruction is a conditional branch.
- actual_takeM  in  1  resolved outcome.
- pred_takeM  in  1  prediction carried with that branch.
- mispredM  out  1  misprediction flag.
- br_cnt  out  32  resolved-branch counter.
- mis_cnt  out  32  misprediction counter.

Function
REQ-003 All counters are 2-bit saturating: 00 SNT, 01 WNT, 10 WT, 11 ST; taken when bit1=1; increment saturates at 11, decrement at 00.
REQ-004 Local index = pc[IDX_W+1:2]; BHT entry LHIST_W bits; local PHT indexed {BHT entry} (2^LHIST_W counters).
REQ-005 Gshare index = pc[GHR_W+1:2] XOR GHR.
REQ-006 CPHT (tournament chooser) indexed by the gshare index; bit1=1 selects global, else local.
REQ-007 Lookup in F is combinational from pcF using current table contents; selected per MODE; result is captured into a D register on clk when stallD=0.
REQ-008 flushD=1 clears the D register to 0 (priority over stallD); stallD=1 and flushD=0 holds it.
REQ-009 pred_takeD = branchD AND D register; latency from pcF to pred_takeD is exactly one cycle.
REQ-010 Update occurs on the clk edge when branchM=1: local PHT and gshare PHT counters each move toward actual_takeM; BHT entry shifts left, inserting actual_takeM at bit0; GHR shifts left, inserting actual_takeM at bit0.
REQ-011 Update indices are computed from pcM and the pre-update BHT/GHR values.
REQ-012 Chooser update (MODE=2 only): local and global predictions are recomputed from pre-update tables at pcM; if exactly one is correct, CPHT moves toward the correct component; otherwise it is unchanged.
REQ-013 Tables and the GHR not used by MODE are neither read nor updated.
REQ-014 If an F lookup and an M update hit the same entry in the same cycle, the lookup sees the pre-update value; no bypass.
REQ-015 mispredM = branchM AND (actual_takeM XOR pred_takeM), combinational.
REQ-016 br_cnt increments on each cycle with branchM=1; mis_cnt increments on each cycle with mispredM=1; both saturate at 32'hFFFF_FFFF.
REQ-017 History and GHR are updated non-speculatively at M only; no recovery logic is required.

Reset
REQ-018 Reset applies when rst=0, asynchronously: BHT entries 0, GHR 0, all PHT counters 01, all CPHT counters 10, D register 0, br_cnt 0, mis_cnt 0.
REQ-019 Reset asserted mid-operation discards any in-flight update; pred_takeD=0 and mispredM follows its inputs.
REQ-020 The first update edge is the first rising clk with rst=1.

Structure
REQ-021 Shared package bpu_pkg holds the MODE encodings (MODE_LOCAL, MODE_GSHARE, MODE_TOURN), the counter encodings and reset values, and a saturating-update function.
REQ-022 A single sub-module, sat_cnt2 (one 2-bit saturating counter with inc/dec enable), is instantiated per table entry or used as the function equivalent.
REQ-023 Tables are flop arrays; no RAM macros are used.

Verification
REQ-024 MODE=0, pc=0x100, four taken resolutions at pcM=0x100 -> BHT[0]=4'b1111; lookup at pcF=0x100 with branchD=1 gives pred_takeD=1 one cycle later.
REQ-025 MODE=1, alternating T/NT at pc=0x200 for 32 resolutions -> prediction accuracy reaches 100% after warm-up; mis_cnt stops incrementing.
REQ-026 MODE=2, a branch where the local predictor is correct and gshare is wrong 2 times -> CPHT entry goes 10 -> 01 -> 00, and the final prediction follows local.
REQ-027 stallD=1 for 3 cycles while pcF changes -> pred_takeD holds its value; flushD=1 together with stallD=1 -> pred_takeD=0 next cycle.
REQ-028 br_cnt preloaded to 32'hFFFF_FFFE (via force), three branchM pulses -> br_cnt=32'hFFFF_FFFF and it stays there.
REQ-029 rst pulsed low asynchronously mid-update between clock edges -> all outputs and tables take reset values immediately; PHT reads 01.
